apb_bridge_ctrl_p: RTL and testbench
====================================

// Module: apb_bridge_ctrl_p
// PURPOSE
//  Parametrised AHB-to-APB bridge controller: converts one qualified AHB transfer into one APB SETUP/ACCESS pair.
//  Adds over the previous generation: N one-hot slave selects decoded from Haddr, Pready wait states,
//  Pslverr and decode-miss mapped to a two-cycle AHB ERROR response, and a configurable ACCESS timeout.
//  Sits between the AHB slave interface (valid/Haddr/Hwrite/Hwdata) and the APB peripherals.
// PARAMETERS
//  ADDR_W   32  address width (Haddr, Paddr)
//  DATA_W   32  data width (Hwdata, Hrdata, Pwdata, Prdata)
//  NUM_SLV  3   number of APB slaves (Psel width), 1..16
//  SEL_LSB  28  LSB of slave-index field in Haddr; field width SW = max(1,$clog2(NUM_SLV))
//  TIMEOUT  16  max ACCESS cycles with Pready=0 before abort; 0 = disabled (wait forever)
// PORTS
//  Hclk       in   1        clock, all logic rising-edge
//  Hreset     in   1        synchronous reset, active-high
//  valid      in   1        qualified AHB transfer (NONSEQ/SEQ, HSEL) in current address phase
//  Haddr      in   ADDR_W   AHB address, sampled with valid
//  Hwrite     in   1        AHB direction, sampled with valid
//  Hwdata     in   DATA_W   AHB write data, sampled in WWAIT
//  Hreadyout  out  1        AHB ready
//  Hresp      out  1        AHB response, 1 = ERROR
//  Hrdata     out  DATA_W   read data, registered
//  Paddr      out  ADDR_W   APB address
//  Pwdata     out  DATA_W   APB write data
//  Pwrite     out  1        APB direction
//  Psel       out  NUM_SLV  APB one-hot slave select
//  Penable    out  1        APB enable
//  Pready     in   1        APB ready
//  Pslverr    in   1        APB slave error, valid with Pready in ACCESS
//  Prdata     in   DATA_W   APB read data
// BEHAVIOUR
//  Reset (sync, Hreset=1 at edge): state IDLE; Hreadyout=1; Hresp=0; Psel=0; Penable=0; Pwrite=0; Paddr/Pwdata/Hrdata=0;
//   timeout counter=0. Reset mid-transfer drops Psel/Penable at that same edge; transfer abandoned, no response.
//  All outputs registered (Moore from state plus captured regs); no combinational input->output path.
//  States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
//  IDLE: Hreadyout=1, Hresp=0. valid sampled ONLY here. On valid: capture Haddr->Paddr, Hwrite->Pwrite,
//   idx = Haddr[SEL_LSB+:SW]. idx>=NUM_SLV -> ERR1 (no APB access). Else write -> WWAIT, read -> SETUP.
//  WWAIT: Hreadyout=0; Hwdata -> Pwdata at end of cycle; -> SETUP.
//  SETUP: Psel[idx]=1, Penable=0, Hreadyout=0; -> ACCESS.
//  ACCESS: Psel[idx]=1, Penable=1, Hreadyout=0. Paddr/Pwrite/Pwdata stable SETUP through ACCESS.
//   Pready=1 & Pslverr=0: read -> Hrdata<=Prdata; -> IDLE (Hreadyout=1, OKAY next cycle).
//   Pready=1 & Pslverr=1: Hrdata unchanged; -> ERR1.
//   Pready=0: counter++; if TIMEOUT!=0 and counter==TIMEOUT-1 -> ERR1 (abort). Counter cleared on SETUP entry.
//  ERR1: Psel=0, Penable=0, Hreadyout=0, Hresp=1; -> ERR2.  ERR2: Hreadyout=1, Hresp=1; -> IDLE.
//  Psel/Penable are 0 in IDLE, WWAIT, ERR1, ERR2. Pslverr ignored when Pready=0.
//  Latency (valid edge N, zero-wait slave): read IDLE->SETUP N+1, ACCESS N+2, Hreadyout=1 with Hrdata at N+3;
//   write WWAIT N+1, SETUP N+2, ACCESS N+3, Hreadyout=1 at N+4. Each Pready=0 cycle adds one.
//  Back-to-back: next valid accepted in the IDLE cycle where Hreadyout returns to 1.
//  Idle with valid=0: state, all APB outputs held.
// TESTING
//  1 Read slv1: valid,Hwrite=0,Haddr=0x1000_0040, Pready=1, Prdata=0xCAFE_F00D -> Psel=3'b010, Paddr=0x1000_0040;
//    Penable one cycle; Hrdata=0xCAFE_F00D, Hreadyout=1, Hresp=0 at N+3.
//  2 Write slv2 with 2 waits: Haddr=0x2000_0008, Hwdata=0x1234_5678, Pready low 2 cycles -> Pwrite=1,
//    Pwdata=0x1234_5678, Psel=3'b100, Hreadyout=1 at N+6.
//  3 Decode miss: Haddr=0x3000_0000 (idx 3, NUM_SLV=3) -> Psel stays 0; Hresp=1 with Hreadyout=0 then 1; IDLE.
//  4 Pslverr: read slv0, Pready=1 & Pslverr=1 -> ERR1/ERR2 pattern, Hrdata unchanged from previous value.
//  5 Timeout: TIMEOUT=16, Pready tied 0 -> Psel/Penable drop after 16 ACCESS cycles, ERROR response, next read OK.
//  6 Reset mid-ACCESS: Hreset=1 during ACCESS -> next edge Psel=0, Penable=0, Hreadyout=1, Hresp=0, Paddr=0.

Source files
------------

// File: rtl/apb_bridge_ctrl_p.sv
// AHB-to-APB bridge controller: one qualified AHB transfer becomes one APB SETUP/ACCESS pair,
// with one-hot slave decode, wait states, error mapping and an optional ACCESS timeout.
//
// state  | meaning
// IDLE   | ready for next AHB transfer, Hreadyout=1
// WWAIT  | write data phase, capture Hwdata
// SETUP  | APB setup, Psel asserted
// ACCESS | APB access, Penable asserted, waiting for Pready
// ERR1   | first ERROR cycle, Hreadyout=0
// ERR2   | second ERROR cycle, Hreadyout=1
module apb_bridge_ctrl_p #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Pwrite,
  output logic [NUM_SLV-1:0] Psel,
  output logic              Penable,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  localparam int SW    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [SW:0]      SLV_LIM  = (SW + 1)'(NUM_SLV);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WWAIT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [SW-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               hready_q, hready_d;
  logic               hresp_q, hresp_d;
  logic [SW-1:0]      addr_idx;

  assign addr_idx = Haddr[SEL_LSB +: SW];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    hrdata_d = hrdata_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          paddr_d  = Haddr;
          pwrite_d = Hwrite;
          idx_d    = addr_idx;
          if ({1'b0, addr_idx} >= SLV_LIM) state_d = S_ERR1;
          else if (Hwrite)                 state_d = S_WWAIT;
          else                             state_d = S_SETUP;
        end
      end
      S_WWAIT: begin
        pwdata_d = Hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (Pready) begin
          if (Pslverr) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = Prdata;
            state_d = S_IDLE;
          end
        end else begin
          // TIMEOUT=0 never aborts; the counter is then free-running and unused
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) state_d = S_ERR1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_SETUP) && (state_q != S_SETUP)) cnt_d = '0;

    // Outputs decoded from the next state so they leave the flops glitch-free
    hready_d  = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
    penable_d = (state_d == S_ACCESS);
    psel_d    = '0;
    if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
      for (int i = 0; i < NUM_SLV; i++) psel_d[i] = (idx_d == SW'(i));
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      hrdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      hrdata_q  <= hrdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
    end
  end

  assign Hreadyout = hready_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = hrdata_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Psel      = psel_q;
  assign Penable   = penable_q;

endmodule

// File: tb/tb_apb_bridge_ctrl_p.sv
// Directed bench for apb_bridge_ctrl_p: an APB slave model plus a scoreboard of
// expected transfer results, compared when each AHB transfer completes.
module tb_apb_bridge_ctrl_p;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic [2:0]  Psel;
  logic        Penable;
  logic        Pready;
  logic        Pslverr;
  logic [31:0] Prdata;

  apb_bridge_ctrl_p #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(28), .TIMEOUT(16)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata), .Paddr(Paddr), .Pwdata(Pwdata),
    .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    logic        hresp;
    int          lat;
    int          pen;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_hrdata = 32'h0;

  int          nwaits_cfg = 0;
  logic        slverr_cfg = 1'b0;
  int          wcnt = 0;

  // APB slave: Pready after nwaits_cfg wait cycles; Pslverr is junk (1) while not ready
  always @(negedge Hclk) begin
    if (Penable && (Psel != 3'b000)) begin
      Pready  = (wcnt >= nwaits_cfg);
      Pslverr = (wcnt >= nwaits_cfg) ? slverr_cfg : 1'b1;
      wcnt++;
    end else begin
      wcnt    = 0;
      Pready  = 1'b0;
      Pslverr = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int nw, input logic se, input logic [31:0] rd);
    exp_t        e;
    exp_t        g;
    int          idx;
    bit          miss;
    bit          err;
    int          acc;
    int          lat;
    int          pen;
    bit          done;
    logic [2:0]  psel_or;
    logic [31:0] o_paddr;
    logic        o_pwrite;
    logic [31:0] o_pwdata;
    idx  = int'(addr[29:28]);
    miss = (idx >= 3);
    acc  = (nw >= 16) ? 16 : nw + 1;
    err  = miss || se || (nw >= 16);
    e.psel   = miss ? 3'b000 : 3'(1 << idx);
    e.paddr  = addr;
    e.pwrite = wr;
    e.pwdata = wd;
    if (!err && !wr) model_hrdata = rd;
    e.hrdata = model_hrdata;
    e.hresp  = err;
    e.lat    = miss ? 2 : (wr ? 1 : 0) + 1 + acc + (err ? 2 : 1);
    e.pen    = miss ? 0 : acc;
    sb.push_back(e);

    nwaits_cfg = nw;
    slverr_cfg = se;
    Prdata     = rd;
    valid  = 1'b1;
    Haddr  = addr;
    Hwrite = wr;
    Hwdata = wd;
    @(posedge Hclk);
    #1;
    valid  = 1'b0;
    Haddr  = $urandom;
    Hwrite = ~wr;

    lat = 0; pen = 0; done = 0; psel_or = 3'b000;
    o_paddr = 32'h0; o_pwrite = 1'b0; o_pwdata = 32'h0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge Hclk);
      lat++;
      psel_or = psel_or | Psel;
      if (Penable) begin
        pen++;
        o_paddr  = Paddr;
        o_pwrite = Pwrite;
        o_pwdata = Pwdata;
      end
      if (Hreadyout) done = 1;
    end

    g = sb.pop_front();
    chk("xfer_done", 32'(done), 32'd1);
    chk("latency", lat, g.lat);
    chk("penable_cycles", pen, g.pen);
    chk("psel", 32'(psel_or), 32'(g.psel));
    chk("hresp", 32'(Hresp), 32'(g.hresp));
    chk("hrdata", Hrdata, g.hrdata);
    if (g.pen > 0) begin
      chk("paddr", o_paddr, g.paddr);
      chk("pwrite", 32'(o_pwrite), 32'(g.pwrite));
      if (g.pwrite) chk("pwdata", o_pwdata, g.pwdata);
    end
    if (g.hresp) begin
      @(negedge Hclk);
      chk("err_idle_hresp", 32'(Hresp), 32'd0);
      chk("err_idle_hready", 32'(Hreadyout), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    Hreset = 1'b1; valid = 1'b0; Haddr = 32'h0; Hwrite = 1'b0; Hwdata = 32'h0;
    Prdata = 32'h0; Pready = 1'b0; Pslverr = 1'b0;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_hready", 32'(Hreadyout), 32'd1);
    chk("rst_hresp", 32'(Hresp), 32'd0);
    chk("rst_psel", 32'(Psel), 32'd0);
    chk("rst_penable", 32'(Penable), 32'd0);
    chk("rst_pwrite", 32'(Pwrite), 32'd0);
    chk("rst_paddr", Paddr, 32'h0);
    chk("rst_pwdata", Pwdata, 32'h0);
    chk("rst_hrdata", Hrdata, 32'h0);
    Hreset = 1'b0;
    repeat (2) @(negedge Hclk);
    chk("idle_hold_paddr", Paddr, 32'h0);

    xfer(32'h1000_0040, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D);   // read slv1
    xfer(32'h2000_0008, 1'b1, 32'h1234_5678, 2, 1'b0, 32'h0);  // write slv2, 2 waits
    xfer(32'h3000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111);  // decode miss
    xfer(32'h0000_0010, 1'b0, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);  // slave error
    xfer(32'h1000_0100, 1'b0, 32'h0, 100, 1'b0, 32'h5555_5555); // timeout
    xfer(32'h0000_0020, 1'b0, 32'h0, 1, 1'b0, 32'hA5A5_1234);  // recovery read
    xfer(32'h1000_0004, 1'b1, 32'hFEED_0001, 0, 1'b0, 32'h0);  // back-to-back write
    xfer(32'h2000_0030, 1'b0, 32'h0, 3, 1'b1, 32'h0BAD_0BAD);  // error after waits

    // reset in the middle of ACCESS
    nwaits_cfg = 5; slverr_cfg = 1'b0; Prdata = 32'h7777_7777;
    valid = 1'b1; Haddr = 32'h2000_0000; Hwrite = 1'b0;
    @(posedge Hclk);
    #1 valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge Hclk);
      if (Penable) seen = 1;
    end
    chk("rst_mid_reached_access", 32'(seen), 32'd1);
    Hreset = 1'b1;
    @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_mid_psel", 32'(Psel), 32'd0);
    chk("rst_mid_penable", 32'(Penable), 32'd0);
    chk("rst_mid_hready", 32'(Hreadyout), 32'd1);
    chk("rst_mid_hresp", 32'(Hresp), 32'd0);
    chk("rst_mid_paddr", Paddr, 32'h0);
    Hreset = 1'b0;
    model_hrdata = 32'h0;
    @(negedge Hclk);
    xfer(32'h1000_0044, 1'b0, 32'h0, 0, 1'b0, 32'h0C0F_FEE0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
